// File: rtl/i2c_xfer_seq_pkg.sv
// i2c_xfer_seq_pkg: i2c_master command codes, sequencer state encoding and response codes.
package i2c_xfer_seq_pkg;
    localparam logic [2:0] START_CMD   = 3'b000;
    localparam logic [2:0] WR_CMD      = 3'b001;
    localparam logic [2:0] RD_CMD      = 3'b010;
    localparam logic [2:0] STOP_CMD    = 3'b011;
    localparam logic [2:0] RESTART_CMD = 3'b100;

    // Each W_x state directly follows its ISS_x state in this encoding.
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ISS_START = 4'd1;
    localparam logic [3:0] S_W_START   = 4'd2;
    localparam logic [3:0] S_ISS_HDR   = 4'd3;
    localparam logic [3:0] S_W_HDR     = 4'd4;
    localparam logic [3:0] S_ISS_DATA  = 4'd5;
    localparam logic [3:0] S_W_DATA    = 4'd6;
    localparam logic [3:0] S_ISS_STOP  = 4'd7;
    localparam logic [3:0] S_W_STOP    = 4'd8;
    localparam logic [3:0] S_RESP      = 4'd9;

    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_NACK_HDR  = 2'b01;
    localparam logic [1:0] ERR_NACK_DATA = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b11;
endpackage

// File: rtl/i2c_xfer_seq_wdog.sv
// i2c_seq_wdog: per-operation watchdog; expire_o rises on the TIMEOUT_CYC-th enabled cycle since clear.
module i2c_seq_wdog #(
    parameter logic [19:0] TIMEOUT_CYC = 20'd200000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    logic [19:0] cnt_q;

    // Cycle counter, restarted on every sequencer state change.
    always_ff @(posedge clk)
        if (!reset || clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 20'd1;

    assign expire_o = en_i && (cnt_q == TIMEOUT_CYC - 20'd1);
endmodule

// File: rtl/i2c_xfer_seq.sv
// i2c_xfer_seq: one register-access transaction (START, header, data, STOP) driven onto i2c_master.
// Optional I2C_SEQ_RETRY_EN: retry header NACKs up to MAX_RETRY times before reporting them.
module i2c_xfer_seq
    import i2c_xfer_seq_pkg::*;
#(
    parameter logic [15:0] DVSR        = 16'd125,
    parameter logic [19:0] TIMEOUT_CYC = 20'd200000
`ifdef I2C_SEQ_RETRY_EN
    ,
    parameter int          MAX_RETRY   = 2
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [6:0]  req_addr,
    input  logic [7:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [1:0]  rsp_err,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic [2:0]  m_cmd,
    output logic [15:0] m_din,
    output logic        m_wr_i2c,
    output logic [15:0] m_dvsr,
    input  logic        m_ready,
    input  logic        m_done_tick,
    input  logic        m_ack,
    input  logic [15:0] m_dout
);
    logic [3:0]  state_q, state_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  reg_q, reg_d;
    logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d, din_q, din_d;
    logic [1:0]  err_q, err_d;
    logic [2:0]  cmd_q, cmd_d;
    logic        wr_q, wr_d;
    logic        expire;
`ifdef I2C_SEQ_RETRY_EN
    logic [3:0]  retry_q, retry_d;
`endif

    i2c_seq_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (state_d != state_q),
        .en_i     (state_q != S_IDLE && state_q != S_RESP),
        .expire_o (expire)
    );

    // Next-state logic; wr_q is high only in the first W_x cycle, where the master's ready is still stale.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cmd_d   = cmd_q;
        din_d   = din_q;
        wr_d    = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            S_IDLE: if (req_valid) begin
                state_d = S_ISS_START;
                rw_d    = req_rw;
                addr_d  = req_addr;
                reg_d   = req_reg;
                wdata_d = req_wdata;
                rdata_d = '0;
                err_d   = ERR_OK;
`ifdef I2C_SEQ_RETRY_EN
                retry_d = '0;
`endif
            end
            S_ISS_START, S_ISS_HDR, S_ISS_DATA, S_ISS_STOP: if (m_ready) begin
                state_d = state_q + 4'd1;
                wr_d    = 1'b1;
                cmd_d   = state_q == S_ISS_START ? START_CMD :
                          state_q == S_ISS_STOP  ? STOP_CMD  :
                          (state_q == S_ISS_DATA && rw_q) ? RD_CMD : WR_CMD;
                din_d   = state_q == S_ISS_HDR  ? {addr_q, rw_q, reg_q} :
                          state_q == S_ISS_DATA ? (rw_q ? 16'h0001 : wdata_q) : 16'h0000;
            end
            S_W_START: if (m_ready && !wr_q) state_d = S_ISS_HDR;
            S_W_HDR: if (m_done_tick) begin
                state_d = m_ack ? S_ISS_STOP : S_ISS_DATA;
                err_d   = m_ack ? ERR_NACK_HDR : err_q;
            end
            S_W_DATA: if (m_done_tick) begin
                state_d = S_ISS_STOP;
                rdata_d = rw_q ? m_dout : rdata_q;
                err_d   = (!rw_q && m_ack) ? ERR_NACK_DATA : err_q;
            end
            S_W_STOP: if (m_ready && !wr_q) begin
                state_d = S_RESP;
`ifdef I2C_SEQ_RETRY_EN
                if (err_q == ERR_NACK_HDR && retry_q < 4'(MAX_RETRY)) begin
                    state_d = S_ISS_START;
                    err_d   = ERR_OK;
                    retry_d = retry_q + 4'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (expire) begin
            state_d = S_RESP;
            wr_d    = 1'b0;
            err_d   = err_q == ERR_OK ? ERR_TIMEOUT : err_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
            cmd_q   <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
`ifdef I2C_SEQ_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign req_ready = state_q == S_IDLE;
    assign busy      = !req_ready;
    assign rsp_valid = state_q == S_RESP;
    assign rsp_err   = err_q;
    assign rsp_rdata = (rsp_valid && rw_q && err_q == ERR_OK) ? rdata_q : '0;
    assign m_cmd     = cmd_q;
    assign m_din     = din_q;
    assign m_wr_i2c  = wr_q;
    assign m_dvsr    = DVSR;
endmodule

// File: tb/tb_i2c_xfer_seq.sv
// tb_i2c_xfer_seq: randomized bench with a behavioural i2c_master/slave model and transaction-level reference.
module tb_i2c_xfer_seq;
    localparam logic [2:0] C_START = 3'b000;
    localparam logic [2:0] C_WR    = 3'b001;
    localparam logic [2:0] C_RD    = 3'b010;
    localparam logic [2:0] C_STOP  = 3'b011;
    localparam logic [6:0] ABSENT  = 7'h21;
`ifdef I2C_SEQ_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_ready, req_rw, rsp_valid, busy, m_wr_i2c;
    logic        m_ready, m_done_tick, m_ack;
    logic [6:0]  req_addr;
    logic [7:0]  req_reg;
    logic [15:0] req_wdata, rsp_rdata, m_din, m_dvsr, m_dout;
    logic [1:0]  rsp_err;
    logic [2:0]  m_cmd;

    int n_vec = 0;
    int n_miss = 0;

    logic [18:0] log_q[$];
    logic        hang = 1'b0;
    logic        nack_data = 1'b0;
    logic [15:0] rd_val = 16'h0;
    int          lat_max = 6;
    int          frame = 0;
    logic [2:0]  mc;
    logic [15:0] md;

    i2c_xfer_seq #(.DVSR(16'd4), .TIMEOUT_CYC(20'd2000)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
        .m_cmd(m_cmd), .m_din(m_din), .m_wr_i2c(m_wr_i2c), .m_dvsr(m_dvsr),
        .m_ready(m_ready), .m_done_tick(m_done_tick), .m_ack(m_ack), .m_dout(m_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Master + slave model: ready stays high for the cycle of the command pulse, then busy for a random time.
    initial begin
        m_ready = 1'b1; m_done_tick = 1'b0; m_ack = 1'b0; m_dout = 16'h0;
        forever begin
            @(posedge clk); #1;
            m_done_tick = 1'b0;
            if (m_wr_i2c) begin
                mc = m_cmd; md = m_din;
                log_q.push_back({mc, md});
                if (mc == C_START) frame = 0;
                @(posedge clk); #1;
                m_ready = 1'b0;
                while (hang && mc == C_START) begin @(posedge clk); #1; end
                repeat ($urandom_range(lat_max, 2)) @(posedge clk);
                #1;
                if (mc == C_WR || mc == C_RD) begin
                    m_done_tick = 1'b1;
                    m_ack  = mc == C_RD ? 1'b1 : frame == 0 ? (md[15:9] == ABSENT) : nack_data;
                    m_dout = mc == C_RD ? rd_val : 16'($urandom);
                    frame++;
                end
                m_ready = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (!(m_ready && req_ready) && k < 500) begin @(posedge clk); #2; k++; end
        check("idle", 32'(m_ready && req_ready), 32'd1);
    endtask

    task automatic run_txn(input logic rw, input logic [6:0] addr, input logic [7:0] rg, input logic [15:0] wd);
        logic [18:0] exp_q[$];
        logic [1:0]  exp_err;
        logic [15:0] exp_rd;
        logic [1:0]  got_err;
        logic [15:0] got_rd;
        logic        present;
        int          k, t_wr, n;
        bit          got;
        present = addr != ABSENT;
        for (int a = 0; a < (present ? 1 : ATTEMPTS); a++) begin
            exp_q.push_back({C_START, 16'h0});
            if (!hang) begin
                exp_q.push_back({C_WR, addr, rw, rg});
                if (present) exp_q.push_back(rw ? {C_RD, 16'h0001} : {C_WR, wd});
                exp_q.push_back({C_STOP, 16'h0});
            end
        end
        exp_err = hang ? 2'b11 : !present ? 2'b01 : (!rw && nack_data) ? 2'b10 : 2'b00;
        exp_rd  = (exp_err == 2'b00 && rw) ? rd_val : 16'h0;
        wait_idle();
        log_q.delete();
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_reg = rg; req_wdata = wd;
        @(posedge clk); #2;
        req_valid = 1'b0; req_rw = 1'($urandom); req_addr = 7'($urandom);
        req_reg = 8'($urandom); req_wdata = 16'($urandom);
        check("busy", 32'(busy), 32'd1);
        got = 0; t_wr = -1; k = 0; got_err = 2'b00; got_rd = 16'h0;
        while (!got && k < 5000) begin
            @(posedge clk); #2; k++;
            if (m_wr_i2c && t_wr < 0) t_wr = k;
            if (rsp_valid) begin got = 1; got_err = rsp_err; got_rd = rsp_rdata; end
        end
        check("rsp_seen", 32'(got), 32'd1);
        check("rsp_err", 32'(got_err), 32'(exp_err));
        check("rsp_rdata", 32'(got_rd), 32'(exp_rd));
        check("n_ops", 32'(log_q.size()), 32'(exp_q.size()));
        n = log_q.size() < exp_q.size() ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check("cmd", 32'(log_q[i][18:16]), 32'(exp_q[i][18:16]));
            if (exp_q[i][18:16] == C_WR || exp_q[i][18:16] == C_RD)
                check("din", 32'(log_q[i][15:0]), 32'(exp_q[i][15:0]));
        end
        if (hang) begin
            check("tmo_latency", 32'(k - t_wr), 32'd2000);
            hang = 1'b0;
        end
        @(posedge clk); #2;
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("ready_after", 32'(req_ready), 32'd1);
    endtask

    task automatic run_abort();
        int  k = 0;
        bit  seen = 0;
        wait_idle();
        log_q.delete();
        nack_data = 1'b0; lat_max = 8;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h48; req_reg = 8'h10; req_wdata = 16'h1234;
        @(posedge clk); #2;
        req_valid = 1'b0;
        while (log_q.size() < 3 && k < 500) begin @(posedge clk); #2; k++; end
        check("reach_wdata", 32'(log_q.size()), 32'd3);
        reset = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        check("abort_wr", 32'(m_wr_i2c), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        repeat (100) begin @(posedge clk); #2; if (rsp_valid) seen = 1; end
        check("abort_rsp", 32'(seen), 32'd0);
    endtask

    initial begin
        logic [6:0] a;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_reg = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_wr", 32'(m_wr_i2c), 32'd0);
        check("rst_cmd", 32'(m_cmd), 32'd0);
        check("rst_din", 32'(m_din), 32'd0);
        check("dvsr", 32'(m_dvsr), 32'd4);
        reset = 1'b1;
        rd_val = 16'hBEEF;
        run_txn(1'b0, 7'h48, 8'h02, 16'hA55A);
        run_txn(1'b1, 7'h48, 8'h05, 16'h0000);
        run_txn(1'b1, ABSENT, 8'h05, 16'h0000);
        nack_data = 1'b1;
        run_txn(1'b0, 7'h48, 8'h07, 16'h5555);
        nack_data = 1'b0;
        hang = 1'b1;
        run_txn(1'b0, 7'h48, 8'h01, 16'h00FF);
        run_txn(1'b1, 7'h48, 8'h05, 16'h0000);
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(4, 0) == 0) a = ABSENT;
            else begin
                a = 7'($urandom);
                while (a == ABSENT) a = 7'($urandom);
            end
            nack_data = $urandom_range(5, 0) == 0;
            rd_val = 16'($urandom);
            lat_max = $urandom_range(10, 3);
            run_txn(1'($urandom), a, 8'($urandom), 16'($urandom));
        end
        run_abort();
        nack_data = 1'b0; rd_val = 16'h0F0F;
        run_txn(1'b1, 7'h48, 8'h22, 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
